// File: rtl/uart_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_sched_pkg
// Shared types and constants for the UART transmit scheduler.
//   sched_state_t : scheduler FSM state encoding
//   HDR_TAG       : upper nibble of the per-packet source-ID header byte
//   GAP_W         : width of the mid-packet stall counter
//   hdr_byte()    : builds the header byte for a requester id
// -----------------------------------------------------------------------------
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } sched_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam int         GAP_W   = 10;

  function automatic logic [7:0] hdr_byte(input logic [3:0] id);
    return {HDR_TAG, id};
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin pick. The search starts at last_id_i+1 and wraps,
// so the most recently served requester has the lowest priority.
//   req_i     in  NUM_REQ  request vector
//   last_id_i in  4        previously granted requester
//   win_o     out 4        winning requester index (valid when any_o)
//   any_o     out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [3:0]         last_id_i,
  output logic [3:0]         win_o,
  output logic               any_o
);

  logic found;

  // Two passes: first the requesters above last_id, then the wrap-around
  // part (0..last_id). The first hit in that order is the winner.
  always_comb begin
    win_o = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (4'(i) > last_id_i)) begin
        found = 1'b1;
        win_o = 4'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (4'(i) <= last_id_i)) begin
        found = 1'b1;
        win_o = 4'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART transmitter between NUM_REQ byte-stream requesters. Grants
// are round-robin at packet boundaries and held until the requester's last
// byte (or a mid-packet stall timeout). Optionally each packet is prefixed
// with a {HDR_TAG, id} header byte.
//   clk        in  1          system clock
//   rst        in  1          asynchronous active-high reset
//   req_vld    in  NUM_REQ    per-requester byte valid
//   req_data   in  NUM_REQ*8  per-requester byte, requester i at [8i+7:8i]
//   req_last   in  NUM_REQ    byte is the last of its packet
//   req_rdy    out NUM_REQ    one-hot accept, combinational from state
//   tx_done    in  1          UART frame complete
//   trmt       out 1          UART load strobe, one-cycle registered pulse
//   tx_data    out 8          UART byte, held until the next load
//   grant_vld  out 1          a packet lock is held
//   grant_id   out 4          locked requester
//   gap_err    out 1          one-cycle pulse when a lock times out
//
// state | meaning
// IDLE  | no lock; arbitrate among valid requesters
// SEND  | lock held; load header or next byte into the UART, count stalls
// WAIT  | UART busy with a frame; wait for a qualified tx_done
// -----------------------------------------------------------------------------
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter bit HDR_EN  = 1'b1,
  parameter int GAP_MAX = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_vld,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_rdy,
  input  logic                 tx_done,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  output logic                 grant_vld,
  output logic [3:0]           grant_id,
  output logic                 gap_err
);

  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_MAX);

  sched_state_t      state_q;
  logic              trmt_q;
  logic [7:0]        tx_data_q;
  logic              grant_vld_q;
  logic [3:0]        grant_id_q;
  logic [3:0]        last_id_q;
  logic              gap_err_q;
  logic              hdr_pend_q;
  logic              end_pend_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_d;

  logic [3:0]        rr_win;
  logic              rr_any;
  logic              sel_vld;
  logic              sel_last;
  logic [7:0]        sel_data;

  rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .req_i     (req_vld),
    .last_id_i (last_id_q),
    .win_o     (rr_win),
    .any_o     (rr_any)
  );

  // Mux out the locked requester's byte stream.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 4'(i)) begin
        sel_vld  = req_vld[i];
        sel_last = req_last[i];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  // Only the lock holder ever sees ready, and only once its header is out.
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = (state_q == SEND) && !hdr_pend_q && (grant_id_q == 4'(i));
    end
  end

  assign gap_d = gap_q + GAP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      trmt_q      <= 1'b0;
      tx_data_q   <= 8'h00;
      grant_vld_q <= 1'b0;
      grant_id_q  <= 4'h0;
      last_id_q   <= 4'(NUM_REQ - 1);
      gap_err_q   <= 1'b0;
      hdr_pend_q  <= 1'b0;
      end_pend_q  <= 1'b0;
      gap_q       <= '0;
    end else begin
      trmt_q    <= 1'b0;
      gap_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rr_any) begin
            grant_id_q  <= rr_win;
            last_id_q   <= rr_win;
            grant_vld_q <= 1'b1;
            hdr_pend_q  <= HDR_EN;
            end_pend_q  <= 1'b0;
            gap_q       <= '0;
            state_q     <= SEND;
          end
        end

        SEND: begin
          if (hdr_pend_q) begin
            trmt_q     <= 1'b1;
            tx_data_q  <= hdr_byte(grant_id_q);
            hdr_pend_q <= 1'b0;
            state_q    <= WAIT;
          end else if (sel_vld) begin
            // A byte arriving on the timeout cycle wins over the timeout.
            trmt_q     <= 1'b1;
            tx_data_q  <= sel_data;
            end_pend_q <= sel_last;
            state_q    <= WAIT;
          end else if (gap_d == GAP_LIM) begin
            gap_q       <= gap_d;
            gap_err_q   <= 1'b1;
            grant_vld_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            gap_q <= gap_d;
          end
        end

        WAIT: begin
          // The UART still shows done from the previous frame while it is
          // being loaded, so tx_done only counts once trmt has dropped.
          if (tx_done && !trmt_q) begin
            gap_q <= '0;
            if (end_pend_q) begin
              grant_vld_q <= 1'b0;
              state_q     <= IDLE;
            end else begin
              state_q <= SEND;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;
  assign gap_err   = gap_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Directed and randomized bench for uart_tx_sched. A behavioural UART holds a
// level tx_done that is still high while it is being loaded, so the WAIT guard
// is exercised on every byte. Expected line traffic, grant order and byte
// spacing come from a packet-level round-robin model.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int NR    = 4;
  localparam int GMAX  = 20;
  localparam int FRAME = 430;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_vld;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_rdy;
  logic            tx_done;
  logic            trmt;
  logic [7:0]      tx_data;
  logic            grant_vld;
  logic [3:0]      grant_id;
  logic            gap_err;

  uart_tx_sched #(
    .NUM_REQ (NR),
    .HDR_EN  (1'b1),
    .GAP_MAX (GMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_rdy   (req_rdy),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .gap_err   (gap_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [8:0] rq [NR][$];
  logic [NR-1:0] hs;
  bit         busy;
  bit         clr_done;
  int         ucnt;
  bit         trmt_prev;
  bit         gv_prev;
  int         done_t;
  int         gv_fall_t;
  int         gap_pulses;
  int         rdy_cnt [NR];
  int         mlast;
  logic [7:0] line [$];
  int         trmt_t [$];
  logic [3:0] gnt_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < NR; i++) if (rq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        req_vld[i]        = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]       = rq[i][0][8];
      end else begin
        req_vld[i]        = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    hs = req_rdy & req_vld;
  endtask

  task automatic clear_logs();
    line.delete();
    trmt_t.delete();
    gnt_log.delete();
    gap_pulses = 0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
  endtask

  task automatic model_reset();
    busy      = 1'b0;
    clr_done  = 1'b0;
    ucnt      = 0;
    tx_done   = 1'b0;
    trmt_prev = 1'b0;
    gv_prev   = 1'b0;
    mlast     = NR - 1;
    for (int i = 0; i < NR; i++) rq[i].delete();
    drive();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    if (clr_done) begin
      tx_done  = 1'b0;
      clr_done = 1'b0;
    end
    if (trmt) begin
      check("trmt_while_uart_busy", 32'(busy), 0);
      check("trmt_width", 32'(trmt_prev), 0);
      line.push_back(tx_data);
      trmt_t.push_back(cyc);
      busy     = 1'b1;
      ucnt     = FRAME;
      clr_done = 1'b1;
    end else if (busy) begin
      ucnt--;
      if (ucnt == 0) begin
        busy    = 1'b0;
        tx_done = 1'b1;
        done_t  = cyc;
      end
    end
    trmt_prev = trmt;
    if (grant_vld && !gv_prev) gnt_log.push_back(grant_id);
    if (!grant_vld && gv_prev) gv_fall_t = cyc;
    gv_prev = grant_vld;
    if (gap_err) gap_pulses++;
    for (int i = 0; i < NR; i++) if (req_rdy[i]) rdy_cnt[i]++;
    if (req_rdy != '0)
      check("rdy_onehot_locked", 32'(req_rdy), grant_vld ? (32'(1) << grant_id) : 32'(0));
    drive();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((grant_vld || busy || pending()) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  task automatic cmp_line(input string tag, input logic [7:0] xq[$]);
    check({tag, "_len"}, line.size(), xq.size());
    for (int j = 0; j < xq.size() && j < line.size(); j++)
      check($sformatf("%s_b%0d", tag, j), 32'(line[j]), 32'(xq[j]));
  endtask

  task automatic cmp_gnt(input string tag, input logic [3:0] xg[$]);
    check({tag, "_len"}, gnt_log.size(), xg.size());
    for (int j = 0; j < xg.size() && j < gnt_log.size(); j++)
      check($sformatf("%s_g%0d", tag, j), 32'(gnt_log[j]), 32'(xg[j]));
  endtask

  // Random packets for every requester, all offered at once; the model serves
  // them round-robin one whole packet at a time.
  task automatic rand_round(input string tag, input int maxpk, input int maxb);
    logic [8:0] mq [NR][$];
    logic [7:0] xl [$];
    bit         xlast [$];
    logic [3:0] xg [$];
    logic [8:0] e;
    int         npk, nb, w, c, t0, iv;
    clear_logs();
    for (int i = 0; i < NR; i++) begin
      npk = $urandom_range(maxpk, 1);
      for (int p = 0; p < npk; p++) begin
        nb = $urandom_range(maxb, 1);
        for (int b = 0; b < nb; b++) begin
          e[7:0] = 8'($urandom);
          e[8]   = (b == nb - 1);
          rq[i].push_back(e);
          mq[i].push_back(e);
        end
      end
    end
    forever begin
      w = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (mlast + k) % NR;
        if (w < 0 && mq[c].size() > 0) w = c;
      end
      if (w < 0) break;
      mlast = w;
      xg.push_back(4'(w));
      xl.push_back({4'hA, 4'(w)});
      xlast.push_back(1'b0);
      do begin
        e = mq[w].pop_front();
        xl.push_back(e[7:0]);
        xlast.push_back(e[8]);
      end while (!e[8]);
    end
    drive();
    t0 = cyc;
    run_until_idle({tag, "_drain"}, 40000);
    if (trmt_t.size() > 0) check({tag, "_grant_latency"}, trmt_t[0] - t0, 2);
    cmp_line(tag, xl);
    cmp_gnt({tag, "_order"}, xg);
    for (int j = 1; j < trmt_t.size() && j < xlast.size(); j++) begin
      iv = xlast[j-1] ? FRAME + 3 : FRAME + 2;
      check($sformatf("%s_spacing%0d", tag, j), trmt_t[j] - trmt_t[j-1], iv);
    end
  endtask

  initial begin
    logic [7:0] xq [$];
    logic [3:0] xg [$];
    int n, t0;

    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    hs       = '0;
    done_t   = 0;
    gv_fall_t = 0;
    model_reset();
    clear_logs();
    repeat (3) tick();
    check("rst_trmt", 32'(trmt), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_rdy", 32'(req_rdy), 0);
    check("rst_grant_vld", 32'(grant_vld), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_gap_err", 32'(gap_err), 0);
    rst = 1'b0;
    tick();

    // Single packet from requester 2 with header.
    clear_logs();
    rq[2].push_back({1'b0, 8'h11});
    rq[2].push_back({1'b1, 8'h22});
    drive();
    t0 = cyc;
    n = 0;
    while (!trmt && n < 10) begin
      tick();
      n++;
    end
    check("a_grant_latency", cyc - t0, 2);
    run_until_idle("a_drain", 5000);
    xq = {8'hA2, 8'h11, 8'h22};
    cmp_line("a_line", xq);
    check("a_grant_fall", gv_fall_t - done_t, 1);
    check("a_rdy2_pulses", rdy_cnt[2], 2);
    check("a_rdy_others", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3], 0);
    xg = {4'd2};
    cmp_gnt("a_order", xg);

    // Requester 3 stalls mid-packet while requester 0 waits; lock times out.
    clear_logs();
    rq[3].push_back({1'b0, 8'h5C});
    rq[0].push_back({1'b1, 8'h0F});
    drive();
    n = 0;
    while (!gap_err && n < 5000) begin
      tick();
      n++;
    end
    check("g_err_seen", 32'(gap_err), 1);
    check("g_err_delay", cyc - done_t, GMAX + 1);
    check("g_grant_drop", 32'(grant_vld), 0);
    tick();
    check("g_err_one_cycle", 32'(gap_err), 0);
    run_until_idle("g_drain", 5000);
    xq = {8'hA3, 8'h5C, 8'hA0, 8'h0F};
    cmp_line("g_line", xq);
    xg = {4'd3, 4'd0};
    cmp_gnt("g_order", xg);
    check("g_err_count", gap_pulses, 1);

    // A byte offered on the very cycle the stall would time out is accepted.
    clear_logs();
    rq[1].push_back({1'b0, 8'h3D});
    drive();
    n = 0;
    while (line.size() < 2 && n < 5000) begin
      tick();
      n++;
    end
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    check("b_reach_done", 32'(n < 5000), 1);
    repeat (GMAX) tick();
    rq[1].push_back({1'b1, 8'h4E});
    drive();
    run_until_idle("b_drain", 5000);
    check("b_no_err", gap_pulses, 0);
    xq = {8'hA1, 8'h3D, 8'h4E};
    cmp_line("b_line", xq);

    // Reset 100 cycles into a frame.
    clear_logs();
    rq[2].push_back({1'b0, 8'h77});
    rq[2].push_back({1'b1, 8'h78});
    drive();
    n = 0;
    while (!trmt && n < 10) begin
      tick();
      n++;
    end
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check("r_trmt", 32'(trmt), 0);
    check("r_tx_data", 32'(tx_data), 0);
    check("r_grant_vld", 32'(grant_vld), 0);
    check("r_grant_id", 32'(grant_id), 0);
    check("r_req_rdy", 32'(req_rdy), 0);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Random traffic after reset, then continuous one-byte packets.
    rand_round("rr1", 2, 3);
    rand_round("rr2", 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
